br_flow_xbar_return: RTL and testbench

Return-path companion to the fixed-priority flow crossbar. It routes responses from NumRespFlows responders back to the NumReqFlows requesters that issued them. For each responder it records the source ID of every forward transfer in arrival order. Each response is steered to the requester at the head of that responder's tag queue. Contention for one requester is resolved by fixed priority, with the lowest responder index winning. It sits beside the forward crossbar on the response side of a many-to-many fabric.

---
 rtl/br_flow_xbar_return_pkg.sv | 14 +
 rtl/br_arb_fixed_internal.sv | 27 ++
 rtl/br_flow_xbar_return_checker.sv | 45 ++++
 rtl/br_flow_xbar_return_tag_queue.sv | 93 +++++++++
 rtl/br_flow_xbar_return.sv | 161 ++++++++++++++++
 tb/tb_br_flow_xbar_return.sv | 257 +++++++++++++++++++++++++
 6 files changed

// File: rtl/br_flow_xbar_return_pkg.sv
// Shared helpers for the flow crossbar return path.
package br_flow_xbar_return_pkg;

    // Index width that never collapses to zero bits, so a single-entry
    // range still has a usable one-bit select.
    function automatic int clamped_clog2(input int value);
        if (value <= 1) begin
            return 1;
        end else begin
            return $clog2(value);
        end
    endfunction

endpackage

// File: rtl/br_arb_fixed_internal.sv
// Fixed-priority arbiter: lowest index wins; enable_i gates the grant
// without changing which request would win.
module br_arb_fixed_internal #(
    parameter int NumRequesters = 1
) (
    input  logic                     enable_i,
    input  logic [NumRequesters-1:0] request_i,
    output logic [NumRequesters-1:0] grant_o
);

    logic taken_s;

    // Scan from index 0 upward; the first active request takes the grant.
    always_comb begin
        grant_o = {NumRequesters{1'b0}};
        taken_s = 1'b0;
        for (int i = 0; i < NumRequesters; i++) begin
            if (request_i[i] && !taken_s) begin
                grant_o[i] = enable_i;
                taken_s    = 1'b1;
            end else begin
                grant_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/br_flow_xbar_return_checker.sv
// Integration properties for the return crossbar (simulation only).
module br_flow_xbar_return_checker #(
    parameter int NumReqFlows    = 1,
    parameter int NumRespFlows   = 1,
    parameter int Width          = 1,
    parameter int MaxOutstanding = 2,
    parameter int SrcIdWidth     = 1,
    parameter int CountWidth     = 2
) (
    input logic                                      clk,
    input logic                                      rst,
    input logic [NumRespFlows-1:0]                   track_push_valid_i,
    input logic [NumRespFlows-1:0][SrcIdWidth-1:0]   track_push_src_id_i,
    input logic [NumRespFlows-1:0]                   resp_push_valid_i,
    input logic [NumRespFlows-1:0]                   resp_push_ready_i,
    input logic [NumRespFlows-1:0][Width-1:0]        resp_push_data_i,
    input logic [NumRespFlows-1:0]                   queue_empty_i,
    input logic [NumRespFlows-1:0][CountWidth-1:0]   queue_count_i,
    input logic [NumReqFlows-1:0]                    ret_pop_valid_i,
    input logic [NumReqFlows-1:0]                    ret_pop_ready_i,
    input logic [NumReqFlows-1:0][Width-1:0]         ret_pop_data_i
);

    for (genvar d = 0; d < NumRespFlows; d++) begin : gen_resp_chk
        a_src_id_range: assert property (@(posedge clk) disable iff (rst)
            track_push_valid_i[d] |-> (int'(track_push_src_id_i[d]) < NumReqFlows));

        a_resp_has_tag: assert property (@(posedge clk) disable iff (rst)
            resp_push_valid_i[d] |-> !queue_empty_i[d]);

        a_count_bound: assert property (@(posedge clk) disable iff (rst)
            int'(queue_count_i[d]) <= MaxOutstanding);

        a_resp_stable: assert property (@(posedge clk) disable iff (rst)
            (resp_push_valid_i[d] && !resp_push_ready_i[d]) |=>
            (resp_push_valid_i[d] && (resp_push_data_i[d] == $past(resp_push_data_i[d]))));
    end

    for (genvar r = 0; r < NumReqFlows; r++) begin : gen_ret_chk
        a_ret_stable: assert property (@(posedge clk) disable iff (rst)
            (ret_pop_valid_i[r] && !ret_pop_ready_i[r]) |=>
            (ret_pop_valid_i[r] && (ret_pop_data_i[r] == $past(ret_pop_data_i[r]))));
    end

endmodule

// File: rtl/br_flow_xbar_return_tag_queue.sv
// Per-responder tag FIFO: remembers which requester issued each
// outstanding forward transfer, oldest entry presented at the head.
module br_flow_xbar_return_tag_queue
    import br_flow_xbar_return_pkg::*;
#(
    parameter int Depth      = 2,
    parameter int DataWidth  = 1,
    parameter int CountWidth = $clog2(Depth + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DataWidth-1:0]  push_data_i,
    input  logic                  pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DataWidth-1:0]  head_o,
    output logic [CountWidth-1:0] count_o
);

    localparam int PtrWidth = clamped_clog2(Depth);

    logic [DataWidth-1:0]  mem_q [Depth];
    logic [PtrWidth-1:0]   wr_ptr_q;
    logic [PtrWidth-1:0]   wr_ptr_d;
    logic [PtrWidth-1:0]   rd_ptr_q;
    logic [PtrWidth-1:0]   rd_ptr_d;
    logic [CountWidth-1:0] count_q;
    logic [CountWidth-1:0] count_d;

    // Pointers wrap explicitly because Depth need not be a power of two.
    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
        if (ptr == PtrWidth'(Depth - 1)) begin
            return {PtrWidth{1'b0}};
        end else begin
            return ptr + PtrWidth'(1);
        end
    endfunction

    // Next-state for pointers and occupancy; push+pop together keeps count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CountWidth'(1);
            2'b01:   count_d = count_q - CountWidth'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PtrWidth{1'b0}};
            rd_ptr_q <= {PtrWidth{1'b0}};
            count_q  <= {CountWidth{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage, cleared on reset so the head is never unknown.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= {DataWidth{1'b0}};
            end
        end else if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign full_o  = (count_q == CountWidth'(Depth));
    assign empty_o = (count_q == {CountWidth{1'b0}});
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/br_flow_xbar_return.sv
// Return path of the fixed-priority flow crossbar: each responder's
// responses are steered to the requester recorded at the head of its tag
// queue, with lowest-index responder winning contention per requester.
module br_flow_xbar_return
    import br_flow_xbar_return_pkg::*;
#(
    parameter int NumReqFlows    = 1,
    parameter int NumRespFlows   = 1,
    parameter int Width          = 1,
    parameter int MaxOutstanding = 2,
    localparam int SrcIdWidth    = clamped_clog2(NumReqFlows),
    localparam int CountWidth    = $clog2(MaxOutstanding + 1)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    output logic [NumRespFlows-1:0]                 track_push_ready,
    input  logic [NumRespFlows-1:0]                 track_push_valid,
    input  logic [NumRespFlows-1:0][SrcIdWidth-1:0] track_push_src_id,
    output logic [NumRespFlows-1:0]                 resp_push_ready,
    input  logic [NumRespFlows-1:0]                 resp_push_valid,
    input  logic [NumRespFlows-1:0][Width-1:0]      resp_push_data,
    input  logic [NumReqFlows-1:0]                  ret_pop_ready,
    output logic [NumReqFlows-1:0]                  ret_pop_valid,
    output logic [NumReqFlows-1:0][Width-1:0]       ret_pop_data
);

    logic [NumRespFlows-1:0]                  full_s;
    logic [NumRespFlows-1:0]                  empty_s;
    logic [NumRespFlows-1:0][SrcIdWidth-1:0]  head_s;
    logic [NumRespFlows-1:0][CountWidth-1:0]  count_s;
    logic [NumRespFlows-1:0]                  track_fire_s;
    logic [NumRespFlows-1:0]                  granted_s;

    logic [NumReqFlows-1:0][NumRespFlows-1:0] arb_req_s;
    logic [NumReqFlows-1:0][NumRespFlows-1:0] arb_grant_s;
    logic [NumReqFlows-1:0]                   can_load_s;
    logic [NumReqFlows-1:0]                   load_s;
    logic [NumReqFlows-1:0][Width-1:0]        load_data_s;

    logic [NumReqFlows-1:0]                   ret_valid_q;
    logic [NumReqFlows-1:0]                   ret_valid_d;
    logic [NumReqFlows-1:0][Width-1:0]        ret_data_q;
    logic [NumReqFlows-1:0][Width-1:0]        ret_data_d;

    // No bypass from a same-cycle pop: a full queue stays not-ready.
    assign track_push_ready = ~full_s & {NumRespFlows{~rst}};
    assign track_fire_s     = track_push_valid & track_push_ready;
    assign resp_push_ready  = granted_s;

    for (genvar d = 0; d < NumRespFlows; d++) begin : gen_resp
        br_flow_xbar_return_tag_queue #(
            .Depth      (MaxOutstanding),
            .DataWidth  (SrcIdWidth),
            .CountWidth (CountWidth)
        ) u_tag_queue (
            .clk         (clk),
            .rst         (rst),
            .push_i      (track_fire_s[d]),
            .push_data_i (track_push_src_id[d]),
            .pop_i       (granted_s[d]),
            .full_o      (full_s[d]),
            .empty_o     (empty_s[d]),
            .head_o      (head_s[d]),
            .count_o     (count_s[d])
        );
    end

    // Build the per-requester request vectors (transposed from responders)
    // and the output-stage load enables.
    always_comb begin
        arb_req_s  = {(NumReqFlows * NumRespFlows){1'b0}};
        can_load_s = {NumReqFlows{1'b0}};
        for (int r = 0; r < NumReqFlows; r++) begin
            can_load_s[r] = !ret_valid_q[r] || ret_pop_ready[r];
            for (int d = 0; d < NumRespFlows; d++) begin
                arb_req_s[r][d] = !rst && resp_push_valid[d] && !empty_s[d] &&
                                  (head_s[d] == SrcIdWidth'(r));
            end
        end
    end

    for (genvar r = 0; r < NumReqFlows; r++) begin : gen_req
        br_arb_fixed_internal #(
            .NumRequesters (NumRespFlows)
        ) u_arb (
            .enable_i  (can_load_s[r]),
            .request_i (arb_req_s[r]),
            .grant_o   (arb_grant_s[r])
        );
    end

    // Fold grants back onto responders and mux winning data per requester.
    always_comb begin
        granted_s   = {NumRespFlows{1'b0}};
        load_s      = {NumReqFlows{1'b0}};
        load_data_s = {(NumReqFlows * Width){1'b0}};
        for (int r = 0; r < NumReqFlows; r++) begin
            load_s[r] = |arb_grant_s[r];
            for (int d = 0; d < NumRespFlows; d++) begin
                granted_s[d]   = granted_s[d] | arb_grant_s[r][d];
                load_data_s[r] = load_data_s[r] |
                                 ({Width{arb_grant_s[r][d]}} & resp_push_data[d]);
            end
        end
    end

    // Output stage next-state: load wins over pop so pop+load reloads.
    always_comb begin
        ret_valid_d = ret_valid_q;
        ret_data_d  = ret_data_q;
        for (int r = 0; r < NumReqFlows; r++) begin
            if (load_s[r]) begin
                ret_valid_d[r] = 1'b1;
                ret_data_d[r]  = load_data_s[r];
            end else if (ret_pop_ready[r]) begin
                ret_valid_d[r] = 1'b0;
                ret_data_d[r]  = ret_data_q[r];
            end else begin
                ret_valid_d[r] = ret_valid_q[r];
                ret_data_d[r]  = ret_data_q[r];
            end
        end
    end

    // One-entry return register per requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_valid_q <= {NumReqFlows{1'b0}};
            ret_data_q  <= {(NumReqFlows * Width){1'b0}};
        end else begin
            ret_valid_q <= ret_valid_d;
            ret_data_q  <= ret_data_d;
        end
    end

    assign ret_pop_valid = ret_valid_q;
    assign ret_pop_data  = ret_data_q;

    br_flow_xbar_return_checker #(
        .NumReqFlows    (NumReqFlows),
        .NumRespFlows   (NumRespFlows),
        .Width          (Width),
        .MaxOutstanding (MaxOutstanding),
        .SrcIdWidth     (SrcIdWidth),
        .CountWidth     (CountWidth)
    ) u_checker (
        .clk                 (clk),
        .rst                 (rst),
        .track_push_valid_i  (track_push_valid),
        .track_push_src_id_i (track_push_src_id),
        .resp_push_valid_i   (resp_push_valid),
        .resp_push_ready_i   (resp_push_ready),
        .resp_push_data_i    (resp_push_data),
        .queue_empty_i       (empty_s),
        .queue_count_i       (count_s),
        .ret_pop_valid_i     (ret_valid_q),
        .ret_pop_ready_i     (ret_pop_ready),
        .ret_pop_data_i      (ret_data_q)
    );

endmodule

// File: tb/tb_br_flow_xbar_return.sv
// Directed bench for br_flow_xbar_return with 2 requesters, 2 responders,
// 8-bit data and 3-deep tag queues.
module tb_br_flow_xbar_return;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      track_push_ready;
    logic [1:0]      track_push_valid;
    logic [1:0][0:0] track_push_src_id;
    logic [1:0]      resp_push_ready;
    logic [1:0]      resp_push_valid;
    logic [1:0][7:0] resp_push_data;
    logic [1:0]      ret_pop_ready;
    logic [1:0]      ret_pop_valid;
    logic [1:0][7:0] ret_pop_data;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    br_flow_xbar_return #(
        .NumReqFlows    (2),
        .NumRespFlows   (2),
        .Width          (8),
        .MaxOutstanding (3)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .track_push_ready  (track_push_ready),
        .track_push_valid  (track_push_valid),
        .track_push_src_id (track_push_src_id),
        .resp_push_ready   (resp_push_ready),
        .resp_push_valid   (resp_push_valid),
        .resp_push_data    (resp_push_data),
        .ret_pop_ready     (ret_pop_ready),
        .ret_pop_valid     (ret_pop_valid),
        .ret_pop_data      (ret_pop_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst               = 1'b1;
        track_push_valid  = 2'b00;
        track_push_src_id = '0;
        resp_push_valid   = 2'b00;
        resp_push_data    = '0;
        ret_pop_ready     = 2'b00;

        // Reset state
        tick();
        tick();
        check("rst_track_ready", 32'(track_push_ready), 32'h0);
        check("rst_resp_ready", 32'(resp_push_ready), 32'h0);
        check("rst_ret_valid", 32'(ret_pop_valid), 32'h0);
        check("rst_ret_data", 32'(ret_pop_data), 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_track_ready", 32'(track_push_ready), 32'h3);

        // Single path: src 1 at resp 0, response 0xA5
        track_push_valid     = 2'b01;
        track_push_src_id[0] = 1'b1;
        tick();
        track_push_valid   = 2'b00;
        resp_push_valid    = 2'b01;
        resp_push_data[0]  = 8'hA5;
        #1;
        check("single_resp_ready", 32'(resp_push_ready), 32'h1);
        tick();
        resp_push_valid = 2'b00;
        #1;
        check("single_ret_valid", 32'(ret_pop_valid), 32'h2);
        check("single_ret_data", 32'(ret_pop_data[1]), 32'hA5);
        check("single_track_ready", 32'(track_push_ready), 32'h3);
        ret_pop_ready = 2'b10;
        tick();
        check("single_popped", 32'(ret_pop_valid), 32'h0);
        ret_pop_ready = 2'b00;

        // Ordering: src 0,1,0 at resp 1, responses 1,2,3
        track_push_valid     = 2'b10;
        track_push_src_id[1] = 1'b0;
        tick();
        track_push_src_id[1] = 1'b1;
        tick();
        track_push_src_id[1] = 1'b0;
        tick();
        track_push_valid = 2'b00;
        #1;
        check("order_q1_full", 32'(track_push_ready), 32'h1);
        ret_pop_ready     = 2'b11;
        resp_push_valid   = 2'b10;
        resp_push_data[1] = 8'h01;
        #1;
        check("order_resp_ready1", 32'(resp_push_ready), 32'h2);
        tick();
        resp_push_data[1] = 8'h02;
        #1;
        check("order_ret1_valid", 32'(ret_pop_valid), 32'h1);
        check("order_ret1_data", 32'(ret_pop_data[0]), 32'h01);
        check("order_resp_ready2", 32'(resp_push_ready), 32'h2);
        tick();
        resp_push_data[1] = 8'h03;
        #1;
        check("order_ret2_valid", 32'(ret_pop_valid), 32'h2);
        check("order_ret2_data", 32'(ret_pop_data[1]), 32'h02);
        tick();
        resp_push_valid = 2'b00;
        #1;
        check("order_ret3_valid", 32'(ret_pop_valid), 32'h1);
        check("order_ret3_data", 32'(ret_pop_data[0]), 32'h03);
        tick();
        check("order_drained", 32'(ret_pop_valid), 32'h0);

        // Contention: both heads target r0
        track_push_valid  = 2'b11;
        track_push_src_id = '0;
        tick();
        track_push_valid  = 2'b00;
        resp_push_valid   = 2'b11;
        resp_push_data[0] = 8'h10;
        resp_push_data[1] = 8'h20;
        #1;
        check("cont_grant_r0", 32'(resp_push_ready), 32'h1);
        tick();
        resp_push_valid = 2'b10;
        #1;
        check("cont_ret_a_valid", 32'(ret_pop_valid), 32'h1);
        check("cont_ret_a_data", 32'(ret_pop_data[0]), 32'h10);
        check("cont_grant_r1", 32'(resp_push_ready), 32'h2);
        tick();
        resp_push_valid = 2'b00;
        #1;
        check("cont_ret_b_valid", 32'(ret_pop_valid), 32'h1);
        check("cont_ret_b_data", 32'(ret_pop_data[0]), 32'h20);
        tick();
        check("cont_drained", 32'(ret_pop_valid), 32'h0);

        // Full queue at resp 0, then back-to-back returns
        track_push_valid     = 2'b01;
        track_push_src_id[0] = 1'b1;
        tick();
        tick();
        tick();
        track_push_valid = 2'b00;
        #1;
        check("full_not_ready", 32'(track_push_ready), 32'h2);
        resp_push_valid   = 2'b01;
        resp_push_data[0] = 8'h33;
        #1;
        check("full_resp_ready", 32'(resp_push_ready), 32'h1);
        check("full_pop_still_not_ready", 32'(track_push_ready), 32'h2);
        tick();
        resp_push_data[0] = 8'h34;
        #1;
        check("full_ready_back", 32'(track_push_ready), 32'h3);
        check("full_ret1_data", 32'(ret_pop_data[1]), 32'h33);
        tick();
        resp_push_data[0] = 8'h35;
        #1;
        check("tput_ret2_valid", 32'(ret_pop_valid), 32'h2);
        check("tput_ret2_data", 32'(ret_pop_data[1]), 32'h34);
        tick();
        resp_push_valid = 2'b00;
        #1;
        check("tput_ret3_data", 32'(ret_pop_data[1]), 32'h35);
        tick();
        check("tput_drained", 32'(ret_pop_valid), 32'h0);

        // Backpressure on r0
        ret_pop_ready        = 2'b00;
        track_push_valid     = 2'b01;
        track_push_src_id[0] = 1'b0;
        tick();
        tick();
        track_push_valid  = 2'b00;
        resp_push_valid   = 2'b01;
        resp_push_data[0] = 8'h41;
        #1;
        check("bp_first_grant", 32'(resp_push_ready), 32'h1);
        tick();
        resp_push_data[0] = 8'h42;
        #1;
        check("bp_loaded_data", 32'(ret_pop_data[0]), 32'h41);
        check("bp_blocked", 32'(resp_push_ready), 32'h0);
        tick();
        check("bp_hold_valid", 32'(ret_pop_valid), 32'h1);
        check("bp_hold_data", 32'(ret_pop_data[0]), 32'h41);
        check("bp_still_blocked", 32'(resp_push_ready), 32'h0);
        ret_pop_ready = 2'b01;
        #1;
        check("bp_release_grant", 32'(resp_push_ready), 32'h1);
        tick();
        resp_push_valid = 2'b00;
        #1;
        check("bp_reload_valid", 32'(ret_pop_valid), 32'h1);
        check("bp_reload_data", 32'(ret_pop_data[0]), 32'h42);
        tick();
        check("bp_drained", 32'(ret_pop_valid), 32'h0);

        // Reset mid-operation
        ret_pop_ready        = 2'b00;
        track_push_valid     = 2'b11;
        track_push_src_id[0] = 1'b0;
        track_push_src_id[1] = 1'b1;
        tick();
        track_push_valid  = 2'b10;
        resp_push_valid   = 2'b01;
        resp_push_data[0] = 8'h55;
        tick();
        track_push_valid = 2'b00;
        resp_push_valid  = 2'b00;
        #1;
        check("mid_ret_valid", 32'(ret_pop_valid), 32'h1);
        check("mid_ret_data", 32'(ret_pop_data[0]), 32'h55);
        rst = 1'b1;
        #1;
        check("mid_rst_track_ready", 32'(track_push_ready), 32'h0);
        tick();
        check("mid_rst_ret_valid", 32'(ret_pop_valid), 32'h0);
        check("mid_rst_ret_data", 32'(ret_pop_data), 32'h0);
        rst = 1'b0;
        #1;
        check("mid_release_ready", 32'(track_push_ready), 32'h3);
        // Two more tags must leave queue 1 below full if its count was cleared
        track_push_valid     = 2'b10;
        track_push_src_id[1] = 1'b0;
        tick();
        tick();
        track_push_valid = 2'b00;
        #1;
        check("mid_count_cleared", 32'(track_push_ready), 32'h3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
